// File: rtl/reg_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapsing, back-pressure and flush.
// Define REG_PIPELINE_COUNT_EN to add the registered occupancy output `count`.
module reg_pipeline #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int CW     = $clog2(STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  input  logic             flush
`ifdef REG_PIPELINE_COUNT_EN
  ,
  output logic [CW-1:0]    count
`endif
);

  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic [STAGES-1:0] rdy;

  // A stage may load when it is empty or its successor can take its contents.
  always_comb begin
    logic r;
    rdy = '0;
    r   = !vld_p[STAGES-1] || out_ready;
    rdy[STAGES-1] = r;
    for (int i = STAGES-2; i >= 0; i--) begin
      r      = !vld_p[i] || r;
      rdy[i] = r;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld_p[STAGES-1];
  assign data_out  = data_p[STAGES-1];

  // ---- stage registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      if (rdy[0]) begin
        vld_p[0] <= in_valid;
        if (in_valid) data_p[0] <= data_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          vld_p[i] <= vld_p[i-1];
          if (vld_p[i-1]) data_p[i] <= data_p[i-1];
        end
      end
    end
  end

`ifdef REG_PIPELINE_COUNT_EN
  logic in_hs, out_hs;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // ---- occupancy counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_hs && !out_hs) begin
      count <= count + CW'(1);
    end else if (out_hs && !in_hs) begin
      count <= count - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline (WIDTH=64, STAGES=3): reset, streaming, back-pressure,
// bubble collapse, flush and asynchronous reset; count is checked when REG_PIPELINE_COUNT_EN is set.
module tb_reg_pipeline;
  localparam int WIDTH  = 64;
  localparam int STAGES = 3;
  localparam int CW     = $clog2(STAGES+1);

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             flush;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  reg_pipeline #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .flush     (flush)
`ifdef REG_PIPELINE_COUNT_EN
    ,
    .count     (count)
`endif
  );

`ifndef REG_PIPELINE_COUNT_EN
  assign count = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef REG_PIPELINE_COUNT_EN
    chk(tag, 64'(count), 64'(exp));
`endif
  endtask

  // Advance past the next rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset asserted between edges; outputs clear immediately.
    #3 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk_cnt("rst_count", 0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    settle();
    chk("rst_rel_out_valid", 64'(out_valid), 64'd0);

    // Streaming 1..4 with out_ready=1.
    out_ready = 1'b1; in_valid = 1'b1; data_in = 64'd1;
    cyc(); chk("s1_out_valid", 64'(out_valid), 64'd0); chk_cnt("s1_count", 1);
    data_in = 64'd2;
    cyc(); chk("s2_out_valid", 64'(out_valid), 64'd0); chk_cnt("s2_count", 2);
    data_in = 64'd3;
    cyc(); chk("s3_out_valid", 64'(out_valid), 64'd1); chk("s3_data", data_out, 64'd1); chk_cnt("s3_count", 3);
    data_in = 64'd4;
    settle(); chk("s4_in_ready_passthru", 64'(in_ready), 64'd1);
    cyc(); chk("s4_data", data_out, 64'd2); chk_cnt("s4_count", 3);
    in_valid = 1'b0;
    cyc(); chk("s5_data", data_out, 64'd3); chk_cnt("s5_count", 2);
    cyc(); chk("s6_data", data_out, 64'd4); chk("s6_out_valid", 64'(out_valid), 64'd1); chk_cnt("s6_count", 1);
    cyc(); chk("s7_out_valid", 64'(out_valid), 64'd0); chk("s7_data_hold", data_out, 64'd4); chk_cnt("s7_count", 0);

    // Back-pressure: offer 5..9 with out_ready=0.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 64'd5;
    cyc(); data_in = 64'd6;
    cyc(); data_in = 64'd7;
    cyc(); chk("bp_full_data", data_out, 64'd5); chk_cnt("bp_full_count", 3);
    data_in = 64'd8;
    settle(); chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    cyc(); chk("bp_stall_data", data_out, 64'd5); chk_cnt("bp_stall_count", 3);
    out_ready = 1'b1;
    settle(); chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    cyc(); chk("bp_d6", data_out, 64'd6); chk_cnt("bp_c6", 3);
    data_in = 64'd9;
    cyc(); chk("bp_d7", data_out, 64'd7); chk("bp_v7", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    cyc(); chk("bp_d8", data_out, 64'd8); chk("bp_v8", 64'(out_valid), 64'd1); chk_cnt("bp_c8", 2);
    cyc(); chk("bp_d9", data_out, 64'd9); chk("bp_v9", 64'(out_valid), 64'd1); chk_cnt("bp_c9", 1);
    cyc(); chk("bp_empty", 64'(out_valid), 64'd0); chk_cnt("bp_c0", 0);

    // Bubble collapse: 9, two idle cycles, 10, with out_ready=0.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 64'd9;
    cyc(); in_valid = 1'b0;
    cyc();
    cyc(); chk("bub_v9", 64'(out_valid), 64'd1);
    in_valid = 1'b1; data_in = 64'd10;
    cyc(); in_valid = 1'b0;
    cyc();
    chk("bub_data", data_out, 64'd9); chk_cnt("bub_count", 2);
    settle(); chk("bub_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(); chk("bub_d10", data_out, 64'd10); chk("bub_v10", 64'(out_valid), 64'd1); chk_cnt("bub_c1", 1);
    cyc(); chk("bub_drained", 64'(out_valid), 64'd0);

    // Flush a full pipe while offering 4.
    out_ready = 1'b0; in_valid = 1'b1; data_in = 64'd1;
    cyc(); data_in = 64'd2;
    cyc(); data_in = 64'd3;
    cyc(); chk_cnt("fl_full_count", 3);
    flush = 1'b1; data_in = 64'd4;
    settle(); chk("fl_in_ready", 64'(in_ready), 64'd0);
    cyc(); chk("fl_out_valid", 64'(out_valid), 64'd0); chk_cnt("fl_count", 0); chk("fl_data_hold", data_out, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("fl_no_4", 64'(out_valid), 64'd0); chk_cnt("fl_count_after", 0);

    // Flush with a simultaneous output handshake.
    in_valid = 1'b1; data_in = 64'd11;
    cyc(); in_valid = 1'b0;
    cyc();
    cyc(); chk("flo_v", 64'(out_valid), 64'd1); chk("flo_d", data_out, 64'd11); chk_cnt("flo_c", 1);
    flush = 1'b1;
    cyc(); chk("flo_out_valid", 64'(out_valid), 64'd0); chk_cnt("flo_count", 0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1; data_in = 64'd20;
    cyc(); data_in = 64'd21;
    cyc(); data_in = 64'd22;
    cyc(); chk("ar_pre_data", data_out, 64'd20); chk_cnt("ar_pre_count", 3);
    #2 reset = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0); chk("ar_data_out", data_out, 64'd0); chk_cnt("ar_count", 0);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    in_valid = 1'b1; data_in = 64'd30;
    cyc(); data_in = 64'd31;
    cyc(); in_valid = 1'b0;
    cyc(); chk("ar_new_v", 64'(out_valid), 64'd1); chk("ar_new_d30", data_out, 64'd30); chk_cnt("ar_new_c", 2);
    cyc(); chk("ar_new_d31", data_out, 64'd31); chk_cnt("ar_new_c1", 1);
    cyc(); chk("ar_end_v", 64'(out_valid), 64'd0); chk_cnt("ar_end_c", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
